// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined two's-complement adder/subtractor rippling one CHUNK-bit slice per stage.
module sumador_segmentado #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int YW = WIDTH - k * CHUNK;
    logic [WIDTH-1:0] xi, x_d, x_q;
    logic [YW-1:0]    yi;
    logic             ci, vi, c_q, v_q;
    logic [CHUNK:0]   s;
    if (k == 0) begin : g_in
      assign xi = a;
      assign yi = sub ? ~b : b;
      assign ci = sub || cin;
      assign vi = in_valid && in_ready;
    end else begin : g_in
      assign xi = g_st[k-1].x_q;
      assign yi = g_st[k-1].g_y.y_q;
      assign ci = g_st[k-1].c_q;
      assign vi = g_st[k-1].v_q;
    end
    assign s = {1'b0, xi[CHUNK-1:0]} + {1'b0, yi[CHUNK-1:0]} + {{CHUNK{1'b0}}, ci};
    // x rotates: unused A slices shift down while finished sum slices enter at the top
    assign x_d = (xi >> CHUNK) | (WIDTH'(s[CHUNK-1:0]) << (WIDTH - CHUNK));
    always_ff @(posedge clk)
      if (rst) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        x_q <= x_d;
        c_q <= s[CHUNK];
        v_q <= vi;
      end
    if (k < STAGES - 1) begin : g_y
      logic [YW-CHUNK-1:0] y_q;
      always_ff @(posedge clk)
        if (rst) y_q <= '0;
        else if (advance) y_q <= yi[YW-1:CHUNK];
    end else begin : g_o
      logic ovf_d, ovf_q;
      assign ovf_d = s[CHUNK] ^ xi[CHUNK-1] ^ yi[CHUNK-1] ^ s[CHUNK-1];
      always_ff @(posedge clk)
        if (rst) ovf_q <= 1'b0;
        else if (advance) ovf_q <= ovf_d;
      assign ovf = ovf_q;
    end
  end
  assign sum       = g_st[STAGES-1].x_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign out_valid = g_st[STAGES-1].v_q;
endmodule

// File: tb/tb_sumador_segmentado.sv
// tb_sumador_segmentado: scoreboard bench for the 64/16 adder plus 8/2 and 8/8 variants.
module tb_sumador_segmentado;
  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          cyc;
    bit          lat;
  } exp_t;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         cyc;
  } e8_t;

  logic        clk = 0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [63:0] a, b, sum;
  logic        ordy, rr, rnd;
  logic        svalid, scin, ssub;
  logic [7:0]  sa, sb;
  logic [1:0]  s_ir, s_ov, s_co, s_of;
  logic [7:0]  s_sum [2];
  logic [63:0] ra, rb;
  logic        rc, rs;
  exp_t        q[$];
  e8_t         sq[2][$];
  exp_t        first;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign out_ready = rr ? rnd : ordy;

  sumador_segmentado #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
    mk.s = s;
    mk.c = c;
    mk.o = o;
    mk.cyc = 0;
    mk.lat = 0;
  endfunction

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
    logic [63:0] yb;
    logic [64:0] r;
    yb = s ? ~y : y;
    r = {1'b0, x} + {1'b0, yb} + {64'd0, s | c};
    model = mk(r[63:0], r[64], (x[63] == yb[63]) && (r[63] != x[63]));
  endfunction

  function automatic e8_t model8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    logic [7:0] yb;
    logic [8:0] r;
    yb = s ? ~y : y;
    r = {1'b0, x} + {1'b0, yb} + {8'd0, s | c};
    model8.s = r[7:0];
    model8.c = r[8];
    model8.o = (x[7] == yb[7]) && (r[7] != x[7]);
    model8.cyc = 0;
  endfunction

  task automatic send(input logic [63:0] ta, input logic [63:0] tb_, input logic tc, input logic ts,
                      input exp_t e, input bit push, input bit lat);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("accept", 64'(acc), 64'(1));
    if (acc && push) begin
      e.cyc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || sq[0].size() != 0 || sq[1].size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(q.size() + sq[0].size() + sq[1].size()), 64'(0));
  endtask

  task automatic rnd_op();
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    rc = 1'($urandom_range(0, 1));
    rs = 1'($urandom_range(0, 1));
  endtask

  // Monitor: every handoff of the 64-bit DUT pops and checks the oldest expectation
  always @(negedge clk) if (!rst && out_valid && out_ready) begin
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_out: got sum %h expected none", sum);
    end else begin
      e = q.pop_front();
      chk("sum", sum, e.s);
      chk("cout", 64'(cout), 64'(e.c));
      chk("ovf", 64'(ovf), 64'(e.o));
      if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(3));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int CH = g == 0 ? 2 : 8;
    localparam int ST = 8 / CH;
    sumador_segmentado #(.WIDTH(8), .CHUNK(CH)) u_small (
      .clk(clk), .rst(rst), .in_valid(svalid), .in_ready(s_ir[g]),
      .a(sa), .b(sb), .cin(scin), .sub(ssub),
      .out_valid(s_ov[g]), .out_ready(1'b1),
      .sum(s_sum[g]), .cout(s_co[g]), .ovf(s_of[g])
    );
    always @(negedge clk) if (!rst && s_ov[g]) begin
      e8_t e;
      if (sq[g].size() == 0) begin
        total++;
        bad++;
        $display("FAIL w8_unexpected[%0d]: got sum %h expected none", g, s_sum[g]);
      end else begin
        e = sq[g].pop_front();
        chk("w8_sum", 64'(s_sum[g]), 64'(e.s));
        chk("w8_cout", 64'(s_co[g]), 64'(e.c));
        chk("w8_ovf", 64'(s_of[g]), 64'(e.o));
        chk("w8_latency", 64'(cyc - e.cyc), 64'(ST - 1));
      end
    end
  end

  initial begin
    rnd = 1;
    forever begin
      @(posedge clk);
      #1;
      rnd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; ordy = 1; rr = 0;
    svalid = 0; sa = 0; sb = 0; scin = 0; ssub = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", sum, 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    // Directed vectors, back to back, hand-computed results
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, mk(64'h0, 1, 0), 1, 1);
    send(64'd5, 64'd7, 0, 1, mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0), 1, 1);
    send(64'd7, 64'd5, 0, 1, mk(64'd2, 1, 0), 1, 1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, mk(64'h8000_0000_0000_0000, 0, 1), 1, 1);
    send(64'h8000_0000_0000_0000, 64'd1, 0, 1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1, 1), 1, 1);
    send(64'd0, 64'd0, 1, 0, mk(64'd1, 0, 0), 1, 1);
    send(64'd3, 64'd3, 0, 1, mk(64'd0, 1, 0), 1, 1);
    send(64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, mk(64'h0000_0001_0000_0000, 0, 0), 1, 1);
    send(64'd10, 64'd3, 1, 1, mk(64'd7, 1, 0), 1, 1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, mk(64'h0, 1, 1), 1, 1);
    drain();
    // Random traffic with random gaps and random out_ready
    rr = 1;
    for (int i = 0; i < 20; i++) begin
      rnd_op();
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1, 0);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    rr = 0;
    drain();
    // Fill the pipeline with out_ready low, then release it
    ordy = 0;
    for (int i = 0; i < 4; i++) begin
      rnd_op();
      if (i == 0) first = model(ra, rb, rc, rs);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1, 0);
    end
    rnd_op();
    a = ra; b = rb; cin = rc; sub = rs; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_sum", sum, first.s);
      @(posedge clk);
      #1;
    end
    ordy = 1;
    @(negedge clk);
    chk("resume_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 0;
    first = model(ra, rb, rc, rs);
    first.cyc = cyc;
    q.push_back(first);
    drain();
    // Reset with three transactions in flight: none may come out
    for (int i = 0; i < 3; i++) begin
      rnd_op();
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 0, 0);
    end
    rst = 1;
    @(negedge clk);
    chk("rst_flight_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_sum", sum, 64'(0));
    chk("flush_cout", 64'(cout), 64'(0));
    chk("flush_ovf", 64'(ovf), 64'(0));
    @(posedge clk);
    #1;
    send(64'd10, 64'd20, 0, 0, mk(64'd30, 0, 0), 1, 1);
    drain();
    repeat (6) @(posedge clk);
    #1;
    // 8-bit variants: every a against 16 b values in three modes, one per cycle
    svalid = 1;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 16; j++)
        for (int m = 0; m < 3; m++) begin
          sa = 8'(i);
          sb = 8'(j * 17);
          scin = m != 0;
          ssub = m == 2;
          @(negedge clk);
          for (int n = 0; n < 2; n++) begin
            e8_t e;
            chk("w8_in_ready", 64'(s_ir[n]), 64'(1));
            e = model8(sa, sb, scin, ssub);
            e.cyc = cyc + 1;
            sq[n].push_back(e);
          end
          @(posedge clk);
          #1;
        end
    svalid = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
